// File: rtl/axisfifo_pkt_if.sv
// rtl/axisfifo_pkt_if.sv - stream handshake bundle for the packet FIFO
interface axisfifo_pkt_if #(
  parameter int DATAW = 32
);
  logic [DATAW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  // Producer side: drives data and framing, observes ready
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // Consumer side of an unframed write stream
  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axisfifo_pkt.sv
// rtl/axisfifo_pkt.sv - first-word-fall-through stream FIFO with packet framing on read
module axisfifo_pkt #(
  parameter int DATAW     = 32,
  parameter int DEPTH     = 512,
  parameter int PKTW      = 16,
  parameter int AFULL_TH  = DEPTH - 8,
  parameter int AEMPTY_TH = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int LW       = AW + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  axisfifo_pkt_if.slave       slave,
  axisfifo_pkt_if.master      master,
  input  logic [PKTW-1:0]     pkt_len,
  input  logic                flush,
  output logic [LW-1:0]       level,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow
);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [PKTW-1:0]  beat_cnt;
  logic [PKTW-1:0]  pkt_len_q;
  logic [1:0]       rst_sync;
  logic             full;
  logic             wr_beat;
  logic             rd_beat;
  logic             first_beat;
  logic             last_raw;

  // Handshake and framing decode, all from registered state plus pkt_len
  always_comb begin
    full          = (level == LW'(DEPTH));
    slave.tready  = rst_sync[1] && !full;
    master.tvalid = (level != '0);
    master.tdata  = mem[rd_ptr];
    wr_beat       = slave.tvalid && slave.tready;
    rd_beat       = master.tvalid && master.tready;
    first_beat    = (beat_cnt == '0);
    // A zero latched length never reaches the compare since the counter holds at 0
    last_raw      = first_beat ? (pkt_len == PKTW'(1))
                               : (beat_cnt == pkt_len_q - PKTW'(1));
    master.tlast  = master.tvalid && last_raw;
    almost_full   = (level >= LW'(AFULL_TH));
    almost_empty  = (level <= LW'(AEMPTY_TH));
  end

  // Two-stage release of reset so writes open on the second edge after deassertion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  // Storage array: not reset, only written on an accepted beat outside flush
  always_ff @(posedge clk) begin
    if (wr_beat && !flush) mem[wr_ptr] <= slave.tdata;
  end

  // Pointers and occupancy; flush drops everything including concurrent beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_beat) wr_ptr <= wr_ptr + AW'(1);
      if (rd_beat) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_beat, rd_beat})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Packet beat counter; length is sampled on each packet's first read beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt  <= '0;
      pkt_len_q <= '0;
    end else if (flush) begin
      beat_cnt  <= '0;
    end else if (rd_beat) begin
      if (first_beat) pkt_len_q <= pkt_len;
      if (master.tlast)                       beat_cnt <= '0;
      else if (first_beat && pkt_len == '0)   beat_cnt <= '0;
      else                                    beat_cnt <= beat_cnt + PKTW'(1);
    end
  end

  // Sticky write-while-full flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  overflow <= 1'b0;
    else if (flush)                overflow <= 1'b0;
    else if (slave.tvalid && full) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_axisfifo_pkt.sv
// tb/tb_axisfifo_pkt.sv - directed self-checking bench for axisfifo_pkt
module tb_axisfifo_pkt;

  localparam int DATAW = 8;
  localparam int DEPTH = 8;
  localparam int PKTW  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [PKTW-1:0] pkt_len = '0;
  logic            flush = 1'b0;
  logic [LW-1:0]   level;
  logic            almost_full;
  logic            almost_empty;
  logic            overflow;

  int checks = 0;
  int failures = 0;

  axisfifo_pkt_if #(.DATAW(DATAW)) s_if ();
  axisfifo_pkt_if #(.DATAW(DATAW)) m_if ();

  axisfifo_pkt #(
    .DATAW(DATAW), .DEPTH(DEPTH), .PKTW(PKTW), .AFULL_TH(6), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .slave(s_if), .master(m_if),
    .pkt_len(pkt_len), .flush(flush), .level(level),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    m_if.tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DATAW'(base + i);
      tick();
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_tready"}, 32'(s_if.tready), 0);
    check({tag, "_tvalid"}, 32'(m_if.tvalid), 0);
    check({tag, "_tlast"}, 32'(m_if.tlast), 0);
    check({tag, "_aempty"}, 32'(almost_empty), 1);
    check({tag, "_afull"}, 32'(almost_full), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  logic exp_last_a [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_last_b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    #3;
    check_reset_values("rst");
    tick();
    reset_n = 1'b1;
    tick();
    check("sync_edge1_tready", 32'(s_if.tready), 0);
    tick();
    check("sync_edge2_tready", 32'(s_if.tready), 1);

    // Fill to full with the head held, then drain in order with no tlast
    pkt_len = 4'd0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'd0;
    check("no_bypass_tvalid", 32'(m_if.tvalid), 0);
    tick();
    check("fwft_tvalid", 32'(m_if.tvalid), 1);
    check("fwft_tdata", 32'(m_if.tdata), 0);
    for (int i = 1; i < 8; i++) begin
      s_if.tdata = DATAW'(i);
      tick();
    end
    s_if.tvalid = 1'b0;
    check("full_level", 32'(level), 8);
    check("full_tready", 32'(s_if.tready), 0);
    check("full_afull", 32'(almost_full), 1);
    check("full_aempty", 32'(almost_empty), 0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_data%0d", i), 32'(m_if.tdata), 32'(i));
      check($sformatf("drain_last%0d", i), 32'(m_if.tlast), 0);
      tick();
    end
    check("drained_tvalid", 32'(m_if.tvalid), 0);
    check("drained_aempty", 32'(almost_empty), 1);

    // Single beat through an empty FIFO with the reader ready
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hA5;
    tick();
    s_if.tvalid = 1'b0;
    check("one_tvalid", 32'(m_if.tvalid), 1);
    check("one_tdata", 32'(m_if.tdata), 32'hA5);
    check("one_level", 32'(level), 1);
    tick();
    check("one_gone_tvalid", 32'(m_if.tvalid), 0);
    check("one_gone_level", 32'(level), 0);

    // Steady state at level 4 with pointers wrapping
    push_n(4, 8'h10);
    for (int k = 0; k < 20; k++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DATAW'(8'h14 + k);
      m_if.tready = 1'b1;
      check($sformatf("ss_data%0d", k), 32'(m_if.tdata), 32'(8'h10 + k));
      check($sformatf("ss_level%0d", k), 32'(level), 4);
      tick();
    end
    s_if.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ss_tail%0d", k), 32'(m_if.tdata), 32'(8'h24 + k));
      tick();
    end
    check("ss_empty", 32'(level), 0);

    // Framing: length 3, switched to 2 mid-packet
    pkt_len = 4'd1;
    #1;
    check("tlast_gated_empty", 32'(m_if.tlast), 0);
    pkt_len = 4'd3;
    push_n(6, 1);
    m_if.tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("pkt_a_data%0d", i), 32'(m_if.tdata), 32'(1 + i));
      check($sformatf("pkt_a_last%0d", i), 32'(m_if.tlast), 32'(exp_last_a[i]));
      tick();
      if (i == 3) pkt_len = 4'd2;
    end
    push_n(4, 7);
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pkt_b_last%0d", i), 32'(m_if.tlast), 32'(exp_last_b[i]));
      tick();
    end

    // Overflow at full, then flush with concurrent beats
    pkt_len = 4'd0;
    push_n(8, 8'h30);
    check("ovf_pre", 32'(overflow), 0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hEE;
    tick();
    s_if.tvalid = 1'b0;
    check("ovf_set", 32'(overflow), 1);
    check("ovf_level", 32'(level), 8);
    check("ovf_head", 32'(m_if.tdata), 32'h30);
    tick();
    check("ovf_sticky", 32'(overflow), 1);
    flush = 1'b1;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    tick();
    flush = 1'b0;
    s_if.tvalid = 1'b0;
    check("flush_level", 32'(level), 0);
    check("flush_tvalid", 32'(m_if.tvalid), 0);
    check("flush_ovf", 32'(overflow), 0);
    check("flush_tready", 32'(s_if.tready), 1);

    // Asynchronous reset mid-packet at level 5
    pkt_len = 4'd3;
    push_n(6, 8'h50);
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    check("pre_rst_level", 32'(level), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("arst");
    tick();
    reset_n = 1'b1;
    tick();
    check("arst_edge1_tready", 32'(s_if.tready), 0);
    tick();
    check("arst_edge2_tready", 32'(s_if.tready), 1);
    push_n(3, 8'h60);
    m_if.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_data%0d", i), 32'(m_if.tdata), 32'(8'h60 + i));
      check($sformatf("arst_last%0d", i), 32'(m_if.tlast), (i == 2) ? 1 : 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
